// File: rtl/d_redirect_ctrl.sv
// Decode-stage redirect sequencer.
// Holds D while a jr operand is outstanding, then raises one registered
// PC-load request toward fetch and keeps it up until fetch takes it.
// Also counts completed redirects and flags an operand wait that runs too long.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | no redirect outstanding; jump requests are sampled here
//   WAIT_OPND | jr accepted, source register not yet resolved; D stalled
//   ISSUE     | pc_load asserted with a stable pc_target until fetch takes it
module d_redirect_ctrl #(
   parameter int DELAY_SLOT = 1,
   parameter int WAIT_MAX   = 15,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             d_valid,
   input  logic             d_jump,
   input  logic             d_jr,
   input  logic             jr_opnd_ready,
   input  logic [31:0]      d_target,
   input  logic             e_stall,
   input  logic             f_stall,
   input  logic             ex_flush,
   output logic             d_stall,
   output logic             pc_load,
   output logic [31:0]      pc_target,
   output logic             f_flush,
   output logic [CNT_W-1:0] redirect_cnt,
   output logic             hazard_timeout
);

   localparam int WCNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_OPND = 2'd1,
      ISSUE     = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WCNT_W-1:0] wait_cnt;
   logic [WCNT_W-1:0] wait_cnt_nxt;
   logic              pc_load_nxt;
   logic              f_flush_nxt;
   logic              latch_tgt;
   logic              cnt_inc;
   logic              timeout_set;
   logic              acc;

   // A jump is only taken from a valid D instruction that is not held downstream.
   assign acc = d_valid & d_jump & ~e_stall;

   // Next-state, stall and registered-output decisions; ex_flush overrides everything.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      pc_load_nxt  = pc_load;
      f_flush_nxt  = 1'b0;
      latch_tgt    = 1'b0;
      cnt_inc      = 1'b0;
      timeout_set  = 1'b0;
      d_stall      = 1'b0;

      if (ex_flush) begin
         state_nxt    = IDLE;
         pc_load_nxt  = 1'b0;
         wait_cnt_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (acc) begin
                  if (!d_jr || jr_opnd_ready) begin
                     latch_tgt   = 1'b1;
                     pc_load_nxt = 1'b1;
                     state_nxt   = ISSUE;
                  end else begin
                     // wait_cnt holds the remaining operand-wait budget
                     d_stall      = 1'b1;
                     wait_cnt_nxt = WCNT_W'(WAIT_MAX);
                     state_nxt    = WAIT_OPND;
                  end
               end
            end
            WAIT_OPND: begin
               d_stall = 1'b1;
               if (jr_opnd_ready) begin
                  latch_tgt    = 1'b1;
                  pc_load_nxt  = 1'b1;
                  wait_cnt_nxt = '0;
                  state_nxt    = ISSUE;
               end else begin
                  if (wait_cnt != '0) begin
                     wait_cnt_nxt = wait_cnt - WCNT_W'(1);
                  end
                  // budget runs out on this edge (or already has)
                  timeout_set = (wait_cnt <= WCNT_W'(1));
               end
            end
            ISSUE: begin
               d_stall     = 1'b1;
               pc_load_nxt = 1'b1;
               if (!f_stall) begin
                  pc_load_nxt = 1'b0;
                  cnt_inc     = 1'b1;
                  f_flush_nxt = (DELAY_SLOT == 0);
                  state_nxt   = IDLE;
               end
            end
            default: begin
               state_nxt   = IDLE;
               pc_load_nxt = 1'b0;
            end
         endcase
      end
   end

   // State, request and operand-wait registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc_load  <= 1'b0;
         f_flush  <= 1'b0;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         pc_load  <= pc_load_nxt;
         f_flush  <= f_flush_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Target is captured only when a redirect is committed; it is left alone afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_target <= '0;
      end else if (latch_tgt) begin
         pc_target <= d_target;
      end
   end

   // Completed-redirect counter, saturating at all ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_cnt <= '0;
      end else if (cnt_inc && (redirect_cnt != '1)) begin
         redirect_cnt <= redirect_cnt + CNT_W'(1);
      end
   end

   // Sticky timeout flag; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hazard_timeout <= 1'b0;
      end else if (timeout_set) begin
         hazard_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_d_redirect_ctrl.sv
// Bench for d_redirect_ctrl: two instances share stimulus, one with the
// architectural delay slot and a wide counter, one flushing F with a 2-bit counter.
module tb_d_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        d_valid, d_jump, d_jr, jr_opnd_ready;
   logic [31:0] d_target;
   logic        e_stall, f_stall, ex_flush;

   logic        d_stall_a, pc_load_a, f_flush_a, timeout_a;
   logic [31:0] pc_target_a;
   logic [15:0] cnt_a;
   logic        d_stall_b, pc_load_b, f_flush_b, timeout_b;
   logic [31:0] pc_target_b;
   logic [1:0]  cnt_b;

   int          checks = 0;
   int          errors = 0;
   int          ecnt_a = 0;
   int          ecnt_b = 0;
   logic [31:0] q_a[$];
   logic [31:0] q_b[$];
   logic [31:0] exp_a, exp_b;

   d_redirect_ctrl #(.DELAY_SLOT(1), .WAIT_MAX(15), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_jump(d_jump), .d_jr(d_jr),
      .jr_opnd_ready(jr_opnd_ready), .d_target(d_target), .e_stall(e_stall),
      .f_stall(f_stall), .ex_flush(ex_flush), .d_stall(d_stall_a), .pc_load(pc_load_a),
      .pc_target(pc_target_a), .f_flush(f_flush_a), .redirect_cnt(cnt_a),
      .hazard_timeout(timeout_a)
   );

   d_redirect_ctrl #(.DELAY_SLOT(0), .WAIT_MAX(15), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_jump(d_jump), .d_jr(d_jr),
      .jr_opnd_ready(jr_opnd_ready), .d_target(d_target), .e_stall(e_stall),
      .f_stall(f_stall), .ex_flush(ex_flush), .d_stall(d_stall_b), .pc_load(pc_load_b),
      .pc_target(pc_target_b), .f_flush(f_flush_b), .redirect_cnt(cnt_b),
      .hazard_timeout(timeout_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic push_exp(input logic [31:0] t);
      q_a.push_back(t);
      q_b.push_back(t);
   endtask

   task automatic note_take();
      ecnt_a++;
      if (ecnt_b < 3) ecnt_b++;
   endtask

   task automatic do_jump(input logic [31:0] t);
      d_valid = 1'b1; d_jump = 1'b1; d_jr = 1'b0; d_target = t;
      push_exp(t);
      settle();
      tick();
      d_valid = 1'b0; d_jump = 1'b0; d_target = 32'h0;
      settle();
      chk("jmp_pc_load", pc_load_a, 1'b1);
      tick();
      note_take();
      settle();
      chk("jmp_cnt_a", cnt_a, ecnt_a);
      chk("jmp_cnt_b", cnt_b, ecnt_b);
      tick();
   endtask

   // Monitor: every PC load that fetch takes must match the next expected target.
   always @(negedge clk) begin
      if (rst_n && !ex_flush && !f_stall && pc_load_a) begin
         if (q_a.size() == 0) begin
            checks++; errors++;
            $display("FAIL mon_a_unexpected: got load of %h expected no load", pc_target_a);
         end else begin
            exp_a = q_a.pop_front();
            chk("mon_a_target", pc_target_a, exp_a);
         end
      end
      if (rst_n && !ex_flush && !f_stall && pc_load_b) begin
         if (q_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL mon_b_unexpected: got load of %h expected no load", pc_target_b);
         end else begin
            exp_b = q_b.pop_front();
            chk("mon_b_target", pc_target_b, exp_b);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; d_valid = 1'b0; d_jump = 1'b0; d_jr = 1'b0; jr_opnd_ready = 1'b0;
      d_target = 32'h0; e_stall = 1'b0; f_stall = 1'b0; ex_flush = 1'b0;
      #1;
      chk("rst_pc_load", pc_load_a, 1'b0);
      chk("rst_pc_target", pc_target_a, 32'h0);
      chk("rst_f_flush", f_flush_b, 1'b0);
      chk("rst_cnt", cnt_a, 16'h0);
      chk("rst_timeout", timeout_a, 1'b0);
      chk("rst_d_stall", d_stall_a, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk); #1 rst_n = 1'b1;
      tick();

      // reset while a load is being held by fetch
      d_valid = 1'b1; d_jump = 1'b1; d_jr = 1'b0; d_target = 32'h00400040; f_stall = 1'b1;
      settle();
      chk("t1_dstall_idle", d_stall_a, 1'b0);
      tick();
      d_valid = 1'b0; d_jump = 1'b0; d_target = 32'h0;
      settle();
      chk("t1_pc_load", pc_load_a, 1'b1);
      chk("t1_pc_target", pc_target_a, 32'h00400040);
      chk("t1_dstall_issue", d_stall_a, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("t1_async_pc_load", pc_load_a, 1'b0);
      chk("t1_async_pc_target", pc_target_a, 32'h0);
      chk("t1_async_dstall", d_stall_a, 1'b0);
      chk("t1_async_pc_load_b", pc_load_b, 1'b0);
      tick();
      @(negedge clk); #1 rst_n = 1'b1; f_stall = 1'b0;
      tick();
      settle();
      chk("t1_idle_pc_load", pc_load_a, 1'b0);
      chk("t1_idle_dstall", d_stall_a, 1'b0);
      tick();

      // direct jump, single-cycle take
      d_valid = 1'b1; d_jump = 1'b1; d_jr = 1'b0; d_target = 32'h00400100;
      push_exp(32'h00400100);
      settle();
      chk("t2_dstall", d_stall_a, 1'b0);
      tick();
      d_valid = 1'b0; d_jump = 1'b0; d_target = 32'hdeadbeef;
      settle();
      chk("t2_pc_load", pc_load_a, 1'b1);
      chk("t2_pc_target", pc_target_a, 32'h00400100);
      chk("t2_pc_load_b", pc_load_b, 1'b1);
      chk("t2_cnt_before", cnt_a, 16'h0);
      chk("t2_f_flush_b_before", f_flush_b, 1'b0);
      tick();
      note_take();
      settle();
      chk("t2_pc_load_drop", pc_load_a, 1'b0);
      chk("t2_cnt_a", cnt_a, ecnt_a);
      chk("t2_cnt_b", cnt_b, ecnt_b);
      chk("t2_f_flush_a", f_flush_a, 1'b0);
      chk("t2_f_flush_b", f_flush_b, 1'b1);
      chk("t2_target_kept", pc_target_a, 32'h00400100);
      tick();
      settle();
      chk("t2_f_flush_b_end", f_flush_b, 1'b0);
      tick();

      // jr with the source register outstanding for three cycles
      d_valid = 1'b1; d_jump = 1'b1; d_jr = 1'b1; jr_opnd_ready = 1'b0; d_target = 32'h0;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) begin
            jr_opnd_ready = 1'b1; d_target = 32'h00400200;
            push_exp(32'h00400200);
         end
         settle();
         chk("t3_dstall", d_stall_a, 1'b1);
         if (c > 0) chk("t3_no_load", pc_load_a, 1'b0);
         tick();
      end
      d_valid = 1'b0; d_jump = 1'b0; d_jr = 1'b0; jr_opnd_ready = 1'b0; d_target = 32'h0;
      settle();
      chk("t3_pc_load", pc_load_a, 1'b1);
      chk("t3_pc_target", pc_target_a, 32'h00400200);
      tick();
      note_take();
      settle();
      chk("t3_pc_load_drop", pc_load_a, 1'b0);
      chk("t3_dstall_idle", d_stall_a, 1'b0);
      chk("t3_cnt_a", cnt_a, ecnt_a);
      chk("t3_f_flush_b", f_flush_b, 1'b1);
      tick();

      // fetch backpressure for two cycles
      d_valid = 1'b1; d_jump = 1'b1; d_jr = 1'b0; d_target = 32'h00400300;
      push_exp(32'h00400300);
      settle();
      tick();
      d_valid = 1'b0; d_jump = 1'b0; d_target = 32'h11111111; f_stall = 1'b1;
      for (int c = 1; c < 4; c++) begin
         if (c == 3) f_stall = 1'b0;
         settle();
         chk("t4_pc_load_held", pc_load_a, 1'b1);
         chk("t4_target_stable", pc_target_a, 32'h00400300);
         chk("t4_dstall", d_stall_a, 1'b1);
         chk("t4_cnt_held", cnt_a, ecnt_a);
         chk("t4_f_flush_b_held", f_flush_b, 1'b0);
         tick();
      end
      note_take();
      settle();
      chk("t4_pc_load_drop", pc_load_a, 1'b0);
      chk("t4_cnt_a", cnt_a, ecnt_a);
      chk("t4_cnt_b", cnt_b, ecnt_b);
      chk("t4_f_flush_b", f_flush_b, 1'b1);
      tick();

      // operand never arrives: timeout, then pipeline flush
      d_valid = 1'b1; d_jump = 1'b1; d_jr = 1'b1; jr_opnd_ready = 1'b0; d_target = 32'h00400700;
      settle();
      chk("t5_dstall_accept", d_stall_a, 1'b1);
      tick();
      for (int c = 1; c <= 20; c++) begin
         settle();
         chk("t5_dstall_wait", d_stall_a, 1'b1);
         chk("t5_no_load", pc_load_a, 1'b0);
         chk("t5_timeout", timeout_a, (c >= 16) ? 1'b1 : 1'b0);
         tick();
      end
      chk("t5_timeout_b", timeout_b, 1'b1);
      ex_flush = 1'b1;
      settle();
      chk("t5_dstall_flush", d_stall_a, 1'b0);
      tick();
      ex_flush = 1'b0; d_valid = 1'b0; d_jump = 1'b0; d_jr = 1'b0; jr_opnd_ready = 1'b1;
      settle();
      chk("t5_post_flush_load", pc_load_a, 1'b0);
      chk("t5_post_flush_dstall", d_stall_a, 1'b0);
      chk("t5_timeout_sticky", timeout_a, 1'b1);
      tick();
      settle();
      chk("t5_no_late_load", pc_load_a, 1'b0);
      chk("t5_cnt_unchanged", cnt_a, ecnt_a);
      tick();
      jr_opnd_ready = 1'b0;

      // e_stall gates acceptance
      d_valid = 1'b1; d_jump = 1'b1; d_jr = 1'b0; d_target = 32'h00400400; e_stall = 1'b1;
      for (int c = 0; c < 2; c++) begin
         settle();
         chk("t6_dstall_estall", d_stall_a, 1'b0);
         if (c == 1) chk("t6_no_accept", pc_load_a, 1'b0);
         tick();
      end
      e_stall = 1'b0;
      push_exp(32'h00400400);
      settle();
      chk("t6_no_accept_yet", pc_load_a, 1'b0);
      tick();
      d_valid = 1'b0; d_jump = 1'b0;
      settle();
      chk("t6_pc_load", pc_load_a, 1'b1);
      chk("t6_pc_target", pc_target_a, 32'h00400400);
      tick();
      note_take();
      settle();
      chk("t6_cnt_a", cnt_a, ecnt_a);
      chk("t6_cnt_b", cnt_b, ecnt_b);
      tick();

      // a jump arriving together with ex_flush is dropped
      d_valid = 1'b1; d_jump = 1'b1; d_target = 32'h00400800; ex_flush = 1'b1;
      settle();
      chk("t6_flush_dstall", d_stall_a, 1'b0);
      tick();
      d_valid = 1'b0; d_jump = 1'b0; ex_flush = 1'b0;
      settle();
      chk("t6_flush_no_load", pc_load_a, 1'b0);
      chk("t6_flush_target_kept", pc_target_a, 32'h00400400);
      tick();

      // counter saturation on the 2-bit instance
      do_jump(32'h00400500);
      do_jump(32'h00400600);
      chk("t6_cnt_a_final", cnt_a, 16'd6);
      chk("t6_cnt_b_sat", cnt_b, 2'd3);
      chk("q_a_drained", q_a.size(), 0);
      chk("q_b_drained", q_b.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
